// File: rtl/interlock_abc_if.sv
// ============================================================================
// Module      : interlock_abc_if
// Description : Request, ring-feedback and grant signals of the A/B/C interlock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interlock_abc_if;
   logic i_A, i_B, i_C;
   logic i_A1, i_B1, i_C1, i_D1, i_E1, i_F1, i_G1, i_H1;
   logic o_A, o_B, o_C;

   modport master (
      output i_A, i_B, i_C,
      output i_A1, i_B1, i_C1, i_D1, i_E1, i_F1, i_G1, i_H1,
      input  o_A, o_B, o_C
   );

   modport slave (
      input  i_A, i_B, i_C,
      input  i_A1, i_B1, i_C1, i_D1, i_E1, i_F1, i_G1, i_H1,
      output o_A, o_B, o_C
   );
endinterface

`default_nettype wire

// File: rtl/interlock_abc.sv
// ============================================================================
// Module      : interlock_abc
// Description : Registered ring interlock for stations A, B, C with fixed
//               priority A > B > C and no pre-emption of a held grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interlock_abc (
   input  logic             clk,
   input  logic             rst,
   interlock_abc_if.slave   bus
);

   // Feedback masks exclude each station's own line from its busy term.
   localparam logic [7:0] c_MASK_A = 8'hFE;
   localparam logic [7:0] c_MASK_B = 8'hFD;
   localparam logic [7:0] c_MASK_C = 8'hFB;

   logic [7:0] w_fb;
   logic       w_busy_a, w_busy_b, w_busy_c;
   logic       w_elig_a, w_elig_b, w_elig_c;
   logic       w_next_a, w_next_b, w_next_c;
   logic       r_grant_a, r_grant_b, r_grant_c;

   assign w_fb = {bus.i_H1, bus.i_G1, bus.i_F1, bus.i_E1,
                  bus.i_D1, bus.i_C1, bus.i_B1, bus.i_A1};

   assign w_busy_a = |(w_fb & c_MASK_A);
   assign w_busy_b = |(w_fb & c_MASK_B);
   assign w_busy_c = |(w_fb & c_MASK_C);

   assign w_elig_a = bus.i_A & ~w_busy_a;
   assign w_elig_b = bus.i_B & ~w_busy_b;
   assign w_elig_c = bus.i_C & ~w_busy_c;

   // A held grant survives a higher-priority newcomer; a new grant needs every
   // higher-priority station to be ineligible. Handover always passes idle.
   assign w_next_a = w_elig_a & ~r_grant_b & ~r_grant_c;
   assign w_next_b = w_elig_b & ~r_grant_a & ~r_grant_c
                   & (r_grant_b | ~w_elig_a);
   assign w_next_c = w_elig_c & ~r_grant_a & ~r_grant_b
                   & (r_grant_c | ~(w_elig_a | w_elig_b));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_a <= 1'b0;
         r_grant_b <= 1'b0;
         r_grant_c <= 1'b0;
      end else begin
         r_grant_a <= w_next_a;
         r_grant_b <= w_next_b;
         r_grant_c <= w_next_c;
      end
   end

   assign bus.o_A = r_grant_a;
   assign bus.o_B = r_grant_b;
   assign bus.o_C = r_grant_c;

endmodule

`default_nettype wire

// File: tb/tb_interlock_abc.sv
// ============================================================================
// Module      : tb_interlock_abc
// Description : Self-checking bench for interlock_abc against a holder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interlock_abc;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   int   holder;   // 0 = idle, 1 = A, 2 = B, 3 = C

   interlock_abc_if bus ();

   interlock_abc dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Holder model: keep the current holder while eligible, otherwise drop to
   // idle; from idle the highest-priority eligible station wins.
   function automatic int model_next(input int cur, input bit [2:0] req, input bit [7:0] fb);
      bit [2:0] elig;
      for (int s = 0; s < 3; s++) begin
         bit [7:0] foreign;
         foreign = fb;
         foreign[s] = 1'b0;
         elig[s] = req[s] && (foreign == 8'h00);
      end
      if (cur != 0) return elig[cur-1] ? cur : 0;
      for (int s = 0; s < 3; s++)
         if (elig[s]) return s + 1;
      return 0;
   endfunction

   function automatic logic [31:0] grants_of(input int h);
      logic [31:0] g;
      g = 32'd0;
      if (h != 0) g[h-1] = 1'b1;
      return g;
   endfunction

   function automatic logic [31:0] observed();
      return {29'd0, bus.o_C, bus.o_B, bus.o_A};
   endfunction

   task automatic step(input bit [2:0] req, input bit [7:0] fb, input string tag);
      @(negedge clk);
      {bus.i_C, bus.i_B, bus.i_A} = req;
      {bus.i_H1, bus.i_G1, bus.i_F1, bus.i_E1,
       bus.i_D1, bus.i_C1, bus.i_B1, bus.i_A1} = fb;
      @(posedge clk);
      #1;
      holder = model_next(holder, req, fb);
      chk(tag, observed(), grants_of(holder));
   endtask

   initial begin
      bit [7:0] fb;
      bit [2:0] req;
      int       k;

      n_checks = 0;
      n_pass   = 0;
      holder   = 0;
      rst      = 1'b1;
      {bus.i_A, bus.i_B, bus.i_C} = 3'b000;
      {bus.i_A1, bus.i_B1, bus.i_C1, bus.i_D1,
       bus.i_E1, bus.i_F1, bus.i_G1, bus.i_H1} = 8'h00;
      #3;
      chk("reset_state", observed(), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-grant, then re-arbitration from idle.
      step(3'b001, 8'h00, "rst_pre_grant");
      #2;
      rst = 1'b1;
      #1;
      holder = 0;
      chk("rst_async_clear", observed(), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_held", observed(), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(3'b001, 8'h00, "rst_release_grant");

      // Foreign feedback blocks and releases A.
      step(3'b001, 8'h10, "a_blocked_by_e");
      step(3'b001, 8'h00, "a_regrant");
      step(3'b000, 8'h00, "a_release");

      // Own feedback ignored, foreign feedback blocks.
      step(3'b010, 8'h02, "b_own_fb");
      step(3'b010, 8'h03, "b_blocked_by_a1");
      step(3'b000, 8'h00, "idle_1");

      // Priority and ordered handover through idle.
      step(3'b111, 8'h00, "prio_a");
      step(3'b110, 8'h00, "a_drop");
      step(3'b110, 8'h00, "b_granted");
      step(3'b100, 8'h00, "b_drop");
      step(3'b100, 8'h00, "c_granted");

      // No pre-emption of a held lower-priority grant.
      step(3'b101, 8'h00, "c_not_preempted");
      step(3'b111, 8'h00, "c_still_held");
      step(3'b011, 8'h00, "c_release");
      step(3'b011, 8'h00, "a_after_c");

      // Request and feedback rising together: feedback wins.
      step(3'b000, 8'h00, "idle_2");
      step(3'b001, 8'h80, "req_fb_same_cycle");

      // Exhaustive own request x foreign feedback per station, from idle.
      for (int s = 0; s < 3; s++) begin
         for (int v = 0; v < 256; v++) begin
            step(3'b000, 8'h00, "exh_idle");
            k = 1;
            for (int j = 0; j < 8; j++) begin
               if (j == s) fb[j] = 1'($urandom_range(0, 1));
               else begin
                  fb[j] = v[k];
                  k++;
               end
            end
            req = 3'b000;
            req[s] = v[0];
            step(req, fb, "exhaustive");
         end
      end

      // Randomized traffic with sparse feedback so grants occur often.
      for (int n = 0; n < 2000; n++) begin
         req = 3'($urandom);
         for (int j = 0; j < 8; j++) fb[j] = ($urandom_range(0, 7) == 0);
         step(req, fb, "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
